// File: rtl/reorder_buffer.sv
// Reorder buffer: accepts up to two dispatches per cycle into slots chosen by the reservation
// station. It records up to two completions per cycle and retires up to two completed
// instructions per cycle in dispatch order. A circular age queue of slot numbers gives that order.
module reorder_buffer #(
    parameter int unsigned ROB_ENTRIES = 16,
    parameter int unsigned PREG_W      = 6,
    parameter int unsigned PC_W        = 32,
    localparam int unsigned IDX_W      = $clog2(ROB_ENTRIES),
    localparam int unsigned NUM_PREG   = 1 << PREG_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   disp_valid1,
    input  logic                   disp_valid2,
    input  logic [IDX_W-1:0]       disp_rob_num1,
    input  logic [IDX_W-1:0]       disp_rob_num2,
    input  logic [PREG_W-1:0]      disp_dest1,
    input  logic [PREG_W-1:0]      disp_dest2,
    input  logic [PREG_W-1:0]      disp_old1,
    input  logic [PREG_W-1:0]      disp_old2,
    input  logic [PC_W-1:0]        disp_pc1,
    input  logic [PC_W-1:0]        disp_pc2,
    input  logic                   cmp_valid1,
    input  logic                   cmp_valid2,
    input  logic [IDX_W-1:0]       cmp_rob_num1,
    input  logic [IDX_W-1:0]       cmp_rob_num2,
    output logic [ROB_ENTRIES-1:0] rob_free,
    output logic [NUM_PREG-1:0]    retire_reg_ready,
    output logic                   ret_valid1,
    output logic                   ret_valid2,
    output logic [PREG_W-1:0]      ret_old1,
    output logic [PREG_W-1:0]      ret_old2,
    output logic [PC_W-1:0]        ret_pc1,
    output logic [PC_W-1:0]        ret_pc2,
    output logic                   disp_err
);

    localparam int unsigned CNT_W = IDX_W + 1;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Per-slot payload and the age-ordered list of slot numbers
    logic [PREG_W-1:0] destMem [ROB_ENTRIES];
    logic [PREG_W-1:0] oldMem  [ROB_ENTRIES];
    logic [PC_W-1:0]   pcMem   [ROB_ENTRIES];
    idx_t              ageQ    [ROB_ENTRIES];

    logic [ROB_ENTRIES-1:0] busyQ, busyD, doneQ, doneD;
    idx_t                   headQ, headD, tailQ, tailD;
    cnt_t                   countQ, countD;

    logic                   retValid1D, retValid2D;
    logic [PREG_W-1:0]      retOld1D, retOld2D;
    logic [PC_W-1:0]        retPc1D, retPc2D;
    logic [NUM_PREG-1:0]    regReadyD;
    logic                   dispErrD;

    idx_t headSlot, nextSlot, tail2;
    logic ret1, ret2, acc1, acc2, we1, we2;

    // Busy bits are already registered, so the free map is simply their complement
    assign rob_free = ~busyQ;

    // Retire selection, dispatch acceptance and all next-state values
    always_comb begin
        headSlot = ageQ[headQ];
        nextSlot = ageQ[headQ + idx_t'(1)];
        ret1     = (countQ != '0) && doneQ[headSlot];
        ret2     = ret1 && (countQ >= cnt_t'(2)) && doneQ[nextSlot];

        // A slot retiring on this edge is still busy, so it is rejected here as well
        acc1  = disp_valid1 && !busyQ[disp_rob_num1];
        acc2  = disp_valid2 && !busyQ[disp_rob_num2]
                && !(disp_valid1 && (disp_rob_num2 == disp_rob_num1));
        we1   = acc1 && !flush;
        we2   = acc2 && !flush;
        tail2 = tailQ + idx_t'(acc1);

        busyD = busyQ;
        doneD = doneQ;
        // Completions only land on busy slots; a slot dispatched this edge is never busy yet
        if (cmp_valid1 && busyQ[cmp_rob_num1]) doneD[cmp_rob_num1] = 1'b1;
        if (cmp_valid2 && busyQ[cmp_rob_num2]) doneD[cmp_rob_num2] = 1'b1;
        if (ret1) begin
            busyD[headSlot] = 1'b0;
            doneD[headSlot] = 1'b0;
        end
        if (ret2) begin
            busyD[nextSlot] = 1'b0;
            doneD[nextSlot] = 1'b0;
        end
        if (acc1) begin
            busyD[disp_rob_num1] = 1'b1;
            doneD[disp_rob_num1] = 1'b0;
        end
        if (acc2) begin
            busyD[disp_rob_num2] = 1'b1;
            doneD[disp_rob_num2] = 1'b0;
        end

        headD  = headQ + idx_t'(ret1) + idx_t'(ret2);
        tailD  = tailQ + idx_t'(acc1) + idx_t'(acc2);
        countD = countQ + cnt_t'(acc1) + cnt_t'(acc2) - cnt_t'(ret1) - cnt_t'(ret2);

        retValid1D = ret1;
        retValid2D = ret2;
        retOld1D   = ret1 ? oldMem[headSlot] : '0;
        retOld2D   = ret2 ? oldMem[nextSlot] : '0;
        retPc1D    = ret1 ? pcMem[headSlot] : '0;
        retPc2D    = ret2 ? pcMem[nextSlot] : '0;
        regReadyD  = '0;
        if (ret1) regReadyD[destMem[headSlot]] = 1'b1;
        if (ret2) regReadyD[destMem[nextSlot]] = 1'b1;

        dispErrD = disp_err | (disp_valid1 & ~acc1) | (disp_valid2 & ~acc2);

        // Flush discards everything on this edge but keeps the sticky error
        if (flush) begin
            busyD      = '0;
            doneD      = '0;
            headD      = '0;
            tailD      = '0;
            countD     = '0;
            retValid1D = 1'b0;
            retValid2D = 1'b0;
            retOld1D   = '0;
            retOld2D   = '0;
            retPc1D    = '0;
            retPc2D    = '0;
            regReadyD  = '0;
            dispErrD   = disp_err;
        end
    end

    // Control state and registered retire outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busyQ            <= '0;
            doneQ            <= '0;
            headQ            <= '0;
            tailQ            <= '0;
            countQ           <= '0;
            ret_valid1       <= 1'b0;
            ret_valid2       <= 1'b0;
            ret_old1         <= '0;
            ret_old2         <= '0;
            ret_pc1          <= '0;
            ret_pc2          <= '0;
            retire_reg_ready <= '0;
            disp_err         <= 1'b0;
        end else begin
            busyQ            <= busyD;
            doneQ            <= doneD;
            headQ            <= headD;
            tailQ            <= tailD;
            countQ           <= countD;
            ret_valid1       <= retValid1D;
            ret_valid2       <= retValid2D;
            ret_old1         <= retOld1D;
            ret_old2         <= retOld2D;
            ret_pc1          <= retPc1D;
            ret_pc2          <= retPc2D;
            retire_reg_ready <= regReadyD;
            disp_err         <= dispErrD;
        end
    end

    // Payload and age-queue writes; contents are only read under busy/count so need no reset
    always_ff @(posedge clk) begin
        if (we1) begin
            destMem[disp_rob_num1] <= disp_dest1;
            oldMem[disp_rob_num1]  <= disp_old1;
            pcMem[disp_rob_num1]   <= disp_pc1;
            ageQ[tailQ]            <= disp_rob_num1;
        end
        if (we2) begin
            destMem[disp_rob_num2] <= disp_dest2;
            oldMem[disp_rob_num2]  <= disp_old2;
            pcMem[disp_rob_num2]   <= disp_pc2;
            ageQ[tail2]            <= disp_rob_num2;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a small age-order model for retire checking.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        disp_valid1, disp_valid2;
    logic [3:0]  disp_rob_num1, disp_rob_num2;
    logic [5:0]  disp_dest1, disp_dest2, disp_old1, disp_old2;
    logic [31:0] disp_pc1, disp_pc2;
    logic        cmp_valid1, cmp_valid2;
    logic [3:0]  cmp_rob_num1, cmp_rob_num2;
    logic [15:0] rob_free;
    logic [63:0] retire_reg_ready;
    logic        ret_valid1, ret_valid2;
    logic [5:0]  ret_old1, ret_old2;
    logic [31:0] ret_pc1, ret_pc2;
    logic        disp_err;

    reorder_buffer #(.ROB_ENTRIES(16), .PREG_W(6), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid1(disp_valid1), .disp_valid2(disp_valid2),
        .disp_rob_num1(disp_rob_num1), .disp_rob_num2(disp_rob_num2),
        .disp_dest1(disp_dest1), .disp_dest2(disp_dest2),
        .disp_old1(disp_old1), .disp_old2(disp_old2),
        .disp_pc1(disp_pc1), .disp_pc2(disp_pc2),
        .cmp_valid1(cmp_valid1), .cmp_valid2(cmp_valid2),
        .cmp_rob_num1(cmp_rob_num1), .cmp_rob_num2(cmp_rob_num2),
        .rob_free(rob_free), .retire_reg_ready(retire_reg_ready),
        .ret_valid1(ret_valid1), .ret_valid2(ret_valid2),
        .ret_old1(ret_old1), .ret_old2(ret_old2),
        .ret_pc1(ret_pc1), .ret_pc2(ret_pc2), .disp_err(disp_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Expected retire order: PC, old preg and slot of each outstanding instruction
    logic [31:0] qPc[$];
    logic [5:0]  qOld[$];
    logic [3:0]  qSlot[$];
    bit          tbBusy[16];
    bit          tbDone[16];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid1 = 0; disp_valid2 = 0; cmp_valid1 = 0; cmp_valid2 = 0;
        disp_rob_num1 = 0; disp_rob_num2 = 0; disp_dest1 = 0; disp_dest2 = 0;
        disp_old1 = 0; disp_old2 = 0; disp_pc1 = 0; disp_pc2 = 0;
        cmp_rob_num1 = 0; cmp_rob_num2 = 0;
    endtask

    task automatic d1(input logic [3:0] s, input logic [5:0] d, input logic [5:0] o,
                      input logic [31:0] pc);
        disp_valid1 = 1; disp_rob_num1 = s; disp_dest1 = d; disp_old1 = o; disp_pc1 = pc;
    endtask

    task automatic d2(input logic [3:0] s, input logic [5:0] d, input logic [5:0] o,
                      input logic [31:0] pc);
        disp_valid2 = 1; disp_rob_num2 = s; disp_dest2 = d; disp_old2 = o; disp_pc2 = pc;
    endtask

    task automatic push(input logic [3:0] s, input logic [5:0] o, input logic [31:0] pc);
        qPc.push_back(pc); qOld.push_back(o); qSlot.push_back(s);
        tbBusy[s] = 1; tbDone[s] = 0;
    endtask

    task automatic popOne(input string tag, input logic [31:0] pc, input logic [5:0] o);
        logic [3:0] s;
        if (qPc.size() == 0) begin
            tests++; fails++;
            $error("FAIL %s_unexpected: observed pc %0h expected no retire", tag, pc);
        end else begin
            s = qSlot.pop_front();
            chk({tag, "_pc"}, pc, qPc.pop_front());
            chk({tag, "_old"}, o, qOld.pop_front());
            chk({tag, "_was_done"}, tbDone[s], 1);
            tbBusy[s] = 0; tbDone[s] = 0;
        end
    endtask

    task automatic checkRet();
        if (ret_valid2) chk("ret2_needs_ret1", ret_valid1, 1);
        if (ret_valid1) popOne("ret1", ret_pc1, ret_old1);
        if (ret_valid2) popOne("ret2", ret_pc2, ret_old2);
    endtask

    initial begin
        int nDisp;
        int st;
        logic [3:0] ds, cs;
        bit haveD, haveC;

        idle();
        // Reset state
        #12;
        chk("rst_free", rob_free, 16'hFFFF);
        chk("rst_rv1", ret_valid1, 0);
        chk("rst_rrr", retire_reg_ready, 0);
        chk("rst_err", disp_err, 0);
        rst_n = 1;
        tick();

        // In-order retire: slot15 older than slot14, slot14 completes first
        d1(4'd15, 6'd7, 6'd1, 32'h100);
        d2(4'd14, 6'd9, 6'd2, 32'h104);
        tick();
        chk("io_free_alloc", rob_free, 16'h3FFF);
        idle(); cmp_valid1 = 1; cmp_rob_num1 = 4'd14;
        tick();
        chk("io_no_ret_a", ret_valid1, 0);
        idle(); cmp_valid1 = 1; cmp_rob_num1 = 4'd15;
        tick();
        chk("io_no_ret_b", ret_valid1, 0);
        idle();
        tick();
        chk("io_rv1", ret_valid1, 1);
        chk("io_rv2", ret_valid2, 1);
        chk("io_pc1", ret_pc1, 32'h100);
        chk("io_pc2", ret_pc2, 32'h104);
        chk("io_old1", ret_old1, 6'd1);
        chk("io_old2", ret_old2, 6'd2);
        chk("io_rrr", retire_reg_ready, (64'd1 << 7) | (64'd1 << 9));
        chk("io_free_after", rob_free, 16'hFFFF);
        tick();
        chk("io_pulse_rv1", ret_valid1, 0);
        chk("io_pulse_rrr", retire_reg_ready, 0);
        chk("io_err", disp_err, 0);

        // Fill all 16 slots, then a dispatch to a full ROB is rejected
        for (int k = 0; k < 8; k++) begin
            idle();
            d1(4'(2 * k), 6'(2 * k), 6'(2 * k + 16), 32'h1000 + 32'(8 * k));
            d2(4'(2 * k + 1), 6'(2 * k + 1), 6'(2 * k + 17), 32'h1004 + 32'(8 * k));
            push(4'(2 * k), 6'(2 * k + 16), 32'h1000 + 32'(8 * k));
            push(4'(2 * k + 1), 6'(2 * k + 17), 32'h1004 + 32'(8 * k));
            tick();
            checkRet();
        end
        chk("full_free", rob_free, 16'h0000);
        idle(); d1(4'd3, 6'd40, 6'd41, 32'hDEAD);
        tick();
        checkRet();
        chk("full_err", disp_err, 1);
        chk("full_free_rej", rob_free, 16'h0000);
        // Drain: completing two per cycle retires all 16 in order
        for (int k = 0; k < 8; k++) begin
            idle(); cmp_valid1 = 1; cmp_rob_num1 = 4'(2 * k);
            cmp_valid2 = 1; cmp_rob_num2 = 4'(2 * k + 1);
            tick();
            checkRet();
            tbDone[2 * k] = 1; tbDone[2 * k + 1] = 1;
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            tick();
            checkRet();
        end
        chk("full_drained", qPc.size(), 0);
        chk("full_free_end", rob_free, 16'hFFFF);

        // Asynchronous reset while a retire pulse is showing
        d1(4'd4, 6'd20, 6'd21, 32'h500);
        d2(4'd5, 6'd22, 6'd23, 32'h504);
        tick();
        idle(); cmp_valid1 = 1; cmp_rob_num1 = 4'd4; cmp_valid2 = 1; cmp_rob_num2 = 4'd5;
        tick();
        idle();
        tick();
        chk("ar_pre_rv1", ret_valid1, 1);
        rst_n = 0;
        #2;
        chk("ar_free", rob_free, 16'hFFFF);
        chk("ar_rv1", ret_valid1, 0);
        chk("ar_rv2", ret_valid2, 0);
        chk("ar_rrr", retire_reg_ready, 0);
        chk("ar_err", disp_err, 0);
        #1;
        rst_n = 1;
        tick();

        // Wrap: 40 dispatches to random free slots, random out-of-order completion
        nDisp = 0;
        for (int cyc = 0; cyc < 300 && (nDisp < 40 || qPc.size() > 0); cyc++) begin
            idle();
            haveD = 0; haveC = 0; ds = 0; cs = 0;
            if (nDisp < 40) begin
                st = int'($urandom_range(0, 15));
                for (int k = 0; k < 16; k++)
                    if (!haveD && !tbBusy[(st + k) % 16]) begin
                        haveD = 1; ds = 4'((st + k) % 16);
                    end
            end
            st = int'($urandom_range(0, 15));
            for (int k = 0; k < 16; k++)
                if (!haveC && tbBusy[(st + k) % 16] && !tbDone[(st + k) % 16]) begin
                    haveC = 1; cs = 4'((st + k) % 16);
                end
            if (haveC) begin
                cmp_valid1 = 1; cmp_rob_num1 = cs;
            end
            if (haveD) begin
                d1(ds, 6'(nDisp), 6'(nDisp + 3), 32'h2000 + 32'(4 * nDisp));
                push(ds, 6'(nDisp + 3), 32'h2000 + 32'(4 * nDisp));
                nDisp++;
            end
            tick();
            checkRet();
            if (haveC) tbDone[cs] = 1;
        end
        chk("wrap_count", nDisp, 40);
        chk("wrap_drained", qPc.size(), 0);
        chk("wrap_err", disp_err, 0);
        chk("wrap_free", rob_free, 16'hFFFF);

        // Same-edge: dispatch to slot 5 as it retires; complete unallocated slot 9
        idle(); d1(4'd5, 6'd10, 6'd11, 32'h3000);
        tick();
        idle(); cmp_valid1 = 1; cmp_rob_num1 = 4'd5;
        tick();
        idle(); d1(4'd5, 6'd12, 6'd13, 32'h3004); cmp_valid2 = 1; cmp_rob_num2 = 4'd9;
        tick();
        chk("se_rv1", ret_valid1, 1);
        chk("se_pc1", ret_pc1, 32'h3000);
        chk("se_err", disp_err, 1);
        chk("se_free", rob_free, 16'hFFFF);
        idle();
        tick();
        chk("se_rv1_after", ret_valid1, 0);
        chk("se_free_after", rob_free, 16'hFFFF);
        d1(4'd9, 6'd14, 6'd15, 32'h3008);
        tick();
        idle();
        tick();
        tick();
        chk("se_9_not_done", ret_valid1, 0);
        chk("se_9_busy", rob_free, 16'hFDFF);

        // Flush with 10 busy entries, oldest one completed and about to retire
        for (int k = 0; k < 4; k++) begin
            idle();
            d1(4'(2 * k), 6'd1, 6'd2, 32'h3100);
            d2(4'(2 * k + 1), 6'd1, 6'd2, 32'h3104);
            tick();
        end
        idle(); d1(4'd8, 6'd1, 6'd2, 32'h3108);
        tick();
        chk("fl_free_10", rob_free, 16'hFC00);
        idle(); cmp_valid1 = 1; cmp_rob_num1 = 4'd9;
        tick();
        chk("fl_pre_rv1", ret_valid1, 0);
        idle(); flush = 1;
        tick();
        flush = 0;
        chk("fl_free", rob_free, 16'hFFFF);
        chk("fl_rv1", ret_valid1, 0);
        chk("fl_rrr", retire_reg_ready, 0);
        chk("fl_err_kept", disp_err, 1);
        d1(4'd0, 6'd12, 6'd3, 32'h4000);
        tick();
        chk("fl_redisp_free", rob_free, 16'hFFFE);
        idle(); cmp_valid1 = 1; cmp_rob_num1 = 4'd0;
        tick();
        idle();
        tick();
        chk("fl_rv1_new", ret_valid1, 1);
        chk("fl_rv2_new", ret_valid2, 0);
        chk("fl_pc_new", ret_pc1, 32'h4000);
        chk("fl_old_new", ret_old1, 6'd3);
        chk("fl_rrr_new", retire_reg_ready, 64'd1 << 12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
